// File: rtl/dlau_ctrl.sv
// dlau_ctrl: job sequencer for the DLAU tile pipeline.
//
// A job runs num_tiles tiles. For each tile the TMMU operand RAM is loaded for
// TILE cycles, the controller waits for the TMMU result and pushes it into the
// result FIFO (stalling on fifo_full). Once every tile is pushed, the FIFO is
// drained into the PSAU one entry per pop, then a one-cycle done pulse ends the job.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, num_tiles        job request; num_tiles latched when start is accepted
//   tmmu_valid              TMMU result ready (only honoured while waiting)
//   fifo_full, fifo_empty   result FIFO status
//   ram_enable              operand RAM load enable (registered)
//   reset_tmmu, reset_psau  synchronous clear pulses (registered)
//   fifo_wr                 FIFO push strobe (combinational on fifo_full)
//   fifo_rd, store_psau     FIFO pop / PSAU accumulate (combinational on fifo_empty)
//   tile_idx                tile in progress (registered)
//   busy, done              job active / completion pulse (registered)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no job; waiting for start
// S_CLR   | one-cycle clear of TMMU and PSAU, counters zeroed
// S_LOAD  | ram_enable for TILE beats
// S_WAIT  | all strobes low until tmmu_valid
// S_PUSH  | write TMMU result into FIFO, hold while fifo_full
// S_DRAIN | pop FIFO into PSAU while not empty until N pops
// S_DONE  | one-cycle done pulse
module dlau_ctrl #(
   parameter int WIDTH = 16,
   parameter int TILE  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_tiles,
   input  logic             tmmu_valid,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   output logic             ram_enable,
   output logic             reset_tmmu,
   output logic             reset_psau,
   output logic             fifo_wr,
   output logic             fifo_rd,
   output logic             store_psau,
   output logic [CNT_W-1:0] tile_idx,
   output logic             busy,
   output logic             done
);

   // WIDTH only travels with the datapath; nothing here depends on it.
   if (WIDTH < 1) begin : g_width_chk
   end

   localparam int                BEAT_W    = (TILE > 1) ? $clog2(TILE) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TILE - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_WAIT, S_PUSH, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  tile_idx_q, tile_idx_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              ram_enable_q, ram_enable_d;
   logic              reset_tmmu_q, reset_tmmu_d;
   logic              reset_psau_q, reset_psau_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Strobes gated by the FIFO flags in the same cycle so a full or empty
   // FIFO is never written or read; PUSH and DRAIN are exclusive states.
   assign fifo_wr    = (state_q == S_PUSH)  && !fifo_full;
   assign fifo_rd    = (state_q == S_DRAIN) && !fifo_empty;
   assign store_psau = fifo_rd;

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      tile_idx_d   = tile_idx_q;
      rd_cnt_d     = rd_cnt_q;
      beat_d       = beat_q;
      reset_tmmu_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_tiles != '0) begin
                  n_d     = num_tiles;
                  state_d = S_CLR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_CLR: begin
            tile_idx_d = '0;
            rd_cnt_d   = '0;
            beat_d     = '0;
            state_d    = S_LOAD;
         end
         S_LOAD: begin
            if (beat_q == BEAT_LAST) begin
               beat_d  = '0;
               state_d = S_WAIT;
            end else begin
               beat_d = beat_q + BEAT_ONE;
            end
         end
         S_WAIT: begin
            if (tmmu_valid) state_d = S_PUSH;
         end
         S_PUSH: begin
            if (fifo_wr) begin
               if (tile_idx_q == n_q - CNT_ONE) begin
                  state_d = S_DRAIN;
               end else begin
                  tile_idx_d   = tile_idx_q + CNT_ONE;
                  reset_tmmu_d = 1'b1;
                  state_d      = S_LOAD;
               end
            end
         end
         S_DRAIN: begin
            if (fifo_rd) begin
               rd_cnt_d = rd_cnt_q + CNT_ONE;
               if (rd_cnt_q == n_q - CNT_ONE) state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_CLR) reset_tmmu_d = 1'b1;
   end

   // Registered outputs are decoded from the next state so they line up
   // with the state they describe.
   assign ram_enable_d = (state_d == S_LOAD);
   assign reset_psau_d = (state_d == S_CLR);
   assign busy_d       = (state_d != S_IDLE);
   assign done_d       = (state_d == S_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         tile_idx_q   <= '0;
         rd_cnt_q     <= '0;
         beat_q       <= '0;
         ram_enable_q <= 1'b0;
         reset_tmmu_q <= 1'b0;
         reset_psau_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         tile_idx_q   <= tile_idx_d;
         rd_cnt_q     <= rd_cnt_d;
         beat_q       <= beat_d;
         ram_enable_q <= ram_enable_d;
         reset_tmmu_q <= reset_tmmu_d;
         reset_psau_q <= reset_psau_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ram_enable = ram_enable_q;
   assign reset_tmmu = reset_tmmu_q;
   assign reset_psau = reset_psau_q;
   assign tile_idx   = tile_idx_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_dlau_ctrl.sv
// Testbench for dlau_ctrl: table-driven jobs, randomized jobs checked against
// a job-level timing model, and an asynchronous reset abort sequence.
module tb_dlau_ctrl;
   localparam int TILE  = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_tiles = '0;
   logic             tmmu_valid = 1'b0;
   logic             fifo_full = 1'b0;
   logic             fifo_empty = 1'b0;
   logic             ram_enable, reset_tmmu, reset_psau;
   logic             fifo_wr, fifo_rd, store_psau;
   logic [CNT_W-1:0] tile_idx;
   logic             busy, done;

   always #5 clk = ~clk;

   dlau_ctrl #(.WIDTH(16), .TILE(TILE), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .num_tiles  (num_tiles),
      .tmmu_valid (tmmu_valid),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .ram_enable (ram_enable),
      .reset_tmmu (reset_tmmu),
      .reset_psau (reset_psau),
      .fifo_wr    (fifo_wr),
      .fifo_rd    (fifo_rd),
      .store_psau (store_psau),
      .tile_idx   (tile_idx),
      .busy       (busy),
      .done       (done)
   );

   // n tiles, vd = extra WAIT cycles before tmmu_valid, fl = full cycles in
   // PUSH, em = fifo_empty pattern over DRAIN cycles (bit i%8), then expected.
   typedef struct {
      int n; int vd; int fl; logic [7:0] em;
      int busy; int ram; int wr; int pops; int rt; int rp;
   } vec_t;

   typedef struct {
      int busy; int ram; int wr; int pops; int rt; int rp;
      int dn; int done_cyc; int end_cyc; int wins; int viol; bit tmo;
   } res_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Busy cycles of one job from its timing rules: CLR, per tile LOAD + WAIT
   // + PUSH, DRAIN until the N-th non-empty cycle, DONE.
   function automatic int model_busy(int n, int vd, int fl, logic [7:0] em);
      int drain = 0;
      int pops  = 0;
      if (n == 0) return 1;
      while (pops < n) begin
         if (!em[drain % 8]) pops++;
         drain++;
      end
      return 1 + n * (TILE + (vd + 1) + (fl + 1)) + drain + 1;
   endfunction

   task automatic run_job(input int n, input int vd, input int fl, input logic [7:0] em,
                          input bit noise, output res_t r);
      int c = 0, wcnt = 0, pcnt = 0, dcnt = 0, tiles = 0, win_len = 0;
      bit prev_ram = 0, seen_busy = 0, in_wait = 0, in_push = 0, in_drain = 0;
      bit push_next = 0, drain_next = 0;
      r.busy = 0; r.ram = 0; r.wr = 0; r.pops = 0; r.rt = 0; r.rp = 0;
      r.dn = 0; r.done_cyc = -1; r.end_cyc = -1; r.wins = 0; r.viol = 0; r.tmo = 0;
      @(negedge clk);
      start      = 1'b1;
      num_tiles  = CNT_W'(n);
      tmmu_valid = 1'b0;
      fifo_full  = 1'b0;
      fifo_empty = 1'b0;
      forever begin
         @(negedge clk);
         c++;
         if (c > 20000) begin r.tmo = 1; break; end
         if (seen_busy && !busy) break;
         start      = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         num_tiles  = noise ? CNT_W'($urandom) : CNT_W'(n);
         tmmu_valid = (noise && ram_enable) ? 1'($urandom_range(0, 1)) : 1'b0;
         fifo_full  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         fifo_empty = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (push_next)  begin in_push = 1; pcnt = 0; push_next = 0; end
         if (drain_next) begin in_drain = 1; dcnt = 0; drain_next = 0; end
         if (prev_ram && !ram_enable) begin in_wait = 1; wcnt = 0; end
         if (in_wait) begin
            tmmu_valid = 1'b0;
            if (wcnt == vd) begin
               tmmu_valid = 1'b1;
               fifo_full  = (fl > 0);
               in_wait    = 0;
               push_next  = 1;
            end
            wcnt++;
         end else if (in_push) begin
            fifo_full = (pcnt < fl);
            if (pcnt >= fl) begin
               in_push = 0;
               tiles++;
               if (tiles == n) drain_next = 1;
            end
            pcnt++;
         end else if (in_drain) begin
            fifo_empty = em[dcnt % 8];
            dcnt++;
         end
         #1;
         if (busy) begin r.busy++; seen_busy = 1; end
         if (ram_enable) begin
            if (!prev_ram) begin
               if (tile_idx != CNT_W'(r.wins)) r.viol++;
               r.wins++;
               win_len = 0;
            end
            win_len++;
            r.ram++;
         end else if (prev_ram && win_len != TILE) begin
            r.viol++;
         end
         prev_ram = ram_enable;
         if (fifo_wr)    r.wr++;
         if (fifo_rd)    r.pops++;
         if (reset_tmmu) r.rt++;
         if (reset_psau) r.rp++;
         if (done) begin r.dn++; r.done_cyc = c; end
         if (c == 1 && n > 0 && !(reset_psau && reset_tmmu)) r.viol++;
         if (fifo_wr && fifo_full)   r.viol++;
         if (fifo_rd && fifo_empty)  r.viol++;
         if (fifo_rd != store_psau)  r.viol++;
         if (fifo_wr && fifo_rd)     r.viol++;
      end
      r.end_cyc  = c;
      start      = 1'b0;
      tmmu_valid = 1'b0;
      fifo_full  = 1'b0;
      fifo_empty = 1'b0;
   endtask

   task automatic check_job(input string lbl, input res_t r, input int n, input int e_busy,
                            input int e_ram, input int e_wr, input int e_pops,
                            input int e_rt, input int e_rp);
      chk({lbl, ".timeout"}, int'(r.tmo), 0);
      chk({lbl, ".busy_cycles"}, r.busy, e_busy);
      chk({lbl, ".ram_cycles"}, r.ram, e_ram);
      chk({lbl, ".load_windows"}, r.wins, n);
      chk({lbl, ".fifo_wr"}, r.wr, e_wr);
      chk({lbl, ".pops"}, r.pops, e_pops);
      chk({lbl, ".reset_tmmu"}, r.rt, e_rt);
      chk({lbl, ".reset_psau"}, r.rp, e_rp);
      chk({lbl, ".done_count"}, r.dn, 1);
      chk({lbl, ".done_cycle"}, r.done_cyc, e_busy);
      chk({lbl, ".busy_fall"}, r.end_cyc, e_busy + 1);
      chk({lbl, ".violations"}, r.viol, 0);
   endtask

   initial begin
      vec_t vecs[7];
      res_t r;
      int   n, vd, fl, idle_done;
      logic [7:0] em;

      vecs[0] = '{1, 3, 0, 8'h00,   40,   32,   1,   1,   1, 1};
      vecs[1] = '{3, 0, 0, 8'h00,  107,   96,   3,   3,   3, 1};
      vecs[2] = '{1, 1, 5, 8'h00,   43,   32,   1,   1,   1, 1};
      vecs[3] = '{0, 0, 0, 8'h00,    1,    0,   0,   0,   0, 0};
      vecs[4] = '{2, 2, 0, 8'h05,   78,   64,   2,   2,   2, 1};
      vecs[5] = '{2, 0, 2, 8'hF0,   76,   64,   2,   2,   2, 1};
      vecs[6] = '{255, 0, 0, 8'h00, 8927, 8160, 255, 255, 255, 1};

      #3;
      chk("por.busy", int'(busy), 0);
      chk("por.ram_enable", int'(ram_enable), 0);
      chk("por.tile_idx", int'(tile_idx), 0);
      chk("por.done", int'(done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_job(vecs[i].n, vecs[i].vd, vecs[i].fl, vecs[i].em, 1'b0, r);
         check_job($sformatf("vec%0d", i), r, vecs[i].n, vecs[i].busy, vecs[i].ram,
                   vecs[i].wr, vecs[i].pops, vecs[i].rt, vecs[i].rp);
      end

      for (int i = 0; i < 15; i++) begin
         n  = $urandom_range(0, 5);
         vd = $urandom_range(0, 4);
         fl = $urandom_range(0, 3);
         em = 8'($urandom) & 8'h7F;
         run_job(n, vd, fl, em, 1'b1, r);
         check_job($sformatf("rnd%0d", i), r, n, model_busy(n, vd, fl, em), n * TILE,
                   n, n, n, (n > 0) ? 1 : 0);
      end

      // Abort a job mid-LOAD with an asynchronous reset away from any clock edge.
      @(negedge clk);
      start     = 1'b1;
      num_tiles = 8'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort.in_load", int'(ram_enable), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort.busy", int'(busy), 0);
      chk("abort.ram_enable", int'(ram_enable), 0);
      chk("abort.tile_idx", int'(tile_idx), 0);
      chk("abort.resets", int'({reset_tmmu, reset_psau}), 0);
      chk("abort.strobes", int'({fifo_wr, fifo_rd, store_psau}), 0);
      chk("abort.done", int'(done), 0);
      idle_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) idle_done++;
      end
      chk("abort.held_idle", idle_done, 0);
      reset_n = 1'b1;
      @(negedge clk);
      run_job(1, 0, 0, 8'h00, 1'b0, r);
      check_job("after_abort", r, 1, 37, 32, 1, 1, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
